// File: rtl/rtc_calendar_core_if.sv
// ---------------------------------------------------------------------------
// rtc_calendar_core_if
// Slot I/O register bus between the card's DEVICE_SELECT decode and the
// calendar core.
//   ADDR     : register index (ADDRESS[3:0] of the slot I/O page)
//   SEL      : one-cycle access strobe
//   WE       : write when SEL=1, read when SEL=1 and WE=0
//   DATA_IN  : write data
//   DATA_OUT : read data, combinational from ADDR and the shadow registers
// ---------------------------------------------------------------------------
interface rtc_calendar_core_if;
    logic [3:0] ADDR;
    logic       SEL;
    logic       WE;
    logic [7:0] DATA_IN;
    logic [7:0] DATA_OUT;

    modport master (output ADDR, output SEL, output WE, output DATA_IN, input DATA_OUT);
    modport slave  (input ADDR, input SEL, input WE, input DATA_IN, output DATA_OUT);
endinterface

// File: rtl/rtc_calendar_core.sv
// ---------------------------------------------------------------------------
// rtc_calendar_core
// BCD calendar clock with a configurable sub-second tick, full month-length
// and leap-year rollover, coherent snapshot reads, hold mode and a
// once-per-second pulse.
//   CLK_14M   : sole clock
//   RESET     : asynchronous active-high reset
//   bus       : register bus (slave side), see rtc_calendar_core_if
//   RTC       : MiSTer 65-bit RTC vector, bit 64 toggles on a new value
//   SEC_PULSE : one-cycle pulse on every seconds increment
// ---------------------------------------------------------------------------
module rtc_calendar_core #(
    parameter int unsigned CLK_HZ  = 32'd14318180,
    parameter int unsigned TICK_HZ = 32'd60,
    parameter logic [7:0]  CENTURY = 8'h20
) (
    input  logic                CLK_14M,
    input  logic                RESET,
    rtc_calendar_core_if.slave  bus,
    input  logic [64:0]         RTC,
    output logic                SEC_PULSE
);
    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;

    typedef struct packed {
        logic [7:0] yr;
        logic [4:0] mon;
        logic [5:0] day;
        logic [2:0] dow;
        logic [5:0] hr;
        logic [6:0] min;
        logic [6:0] sec;
    } cal_t;

    localparam cal_t CAL_RESET = '{yr: 8'h00, mon: 5'h01, day: 6'h01, dow: 3'd6,
                                   hr: 6'h00, min: 7'h00, sec: 7'h00};

    cal_t          cal_r, cal_s, shadow_r, shadow_s;
    logic [PW-1:0] presc_r, presc_s;
    logic [5:0]    subsec_r, subsec_s;
    logic          hold_r, hold_s, pending_r, pending_s;
    logic          rtc_tog_r, sec_pulse_r, sec_pulse_s;
    logic          tick_s, sec_event_s, rtc_load_s, bus_wr_s, field_wr_s, snap_s, clear_cnt_s;
    logic [3:0]    wr_nib_s;
    logic [7:0]    rd_data_s;
    logic          unused_s;

    // BCD digit increments; the tens digit simply wraps at the field width.
    function automatic logic [4:0] bcd5(input logic [4:0] v);
        return (v[3:0] == 4'd9) ? {v[4] + 1'b1, 4'd0} : {v[4], v[3:0] + 4'd1};
    endfunction
    function automatic logic [5:0] bcd6(input logic [5:0] v);
        return (v[3:0] == 4'd9) ? {v[5:4] + 2'd1, 4'd0} : {v[5:4], v[3:0] + 4'd1};
    endfunction
    function automatic logic [6:0] bcd7(input logic [6:0] v);
        return (v[3:0] == 4'd9) ? {v[6:4] + 3'd1, 4'd0} : {v[6:4], v[3:0] + 4'd1};
    endfunction
    function automatic logic [7:0] bcd8(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    // One-second advance with the whole carry chain resolved combinationally.
    function automatic cal_t cal_inc(input cal_t c);
        cal_t       r;
        logic       leap, c_min, c_hr, c_day, c_mon, c_yr;
        logic [5:0] day_max;
        // (10*tens + ones) mod 4 equals (2*tens + ones) mod 4
        leap = (({c.yr[4], 1'b0} + c.yr[1:0]) == 2'b00);
        case (c.mon)
            5'h04, 5'h06, 5'h09, 5'h11: day_max = 6'h30;
            5'h02:                      day_max = leap ? 6'h29 : 6'h28;
            default:                    day_max = 6'h31;
        endcase
        c_min = (c.sec == 7'h59);
        c_hr  = c_min && (c.min == 7'h59);
        c_day = c_hr && (c.hr == 6'h23);
        c_mon = c_day && (c.day == day_max);
        c_yr  = c_mon && (c.mon == 5'h12);
        r.sec = c_min ? 7'h00 : bcd7(c.sec);
        r.min = !c_min ? c.min : (c_hr ? 7'h00 : bcd7(c.min));
        r.hr  = !c_hr ? c.hr : (c_day ? 6'h00 : bcd6(c.hr));
        r.dow = !c_day ? c.dow : ((c.dow == 3'd6) ? 3'd0 : c.dow + 3'd1);
        r.day = !c_day ? c.day : (c_mon ? 6'h01 : bcd6(c.day));
        r.mon = !c_mon ? c.mon : (c_yr ? 5'h01 : bcd5(c.mon));
        r.yr  = !c_yr ? c.yr : ((c.yr == 8'h99) ? 8'h00 : bcd8(c.yr));
        return r;
    endfunction

    assign unused_s = ^{RTC[63:51], RTC[39:37], RTC[31:30], RTC[23:22], RTC[15], RTC[7],
                        bus.DATA_IN[6:4]};

    // Event decode, counters and the load > write > second-event priority chain.
    always_comb begin
        rtc_load_s  = RTC[64] ^ rtc_tog_r;
        bus_wr_s    = bus.SEL & bus.WE;
        field_wr_s  = bus_wr_s && (bus.ADDR >= 4'h2) && (bus.ADDR <= 4'hE);
        snap_s      = bus.SEL && !bus.WE && (bus.ADDR == 4'h0);
        tick_s      = (presc_r == PW'(DIV - 32'd1));
        sec_event_s = tick_s && (subsec_r == 6'(TICK_HZ - 32'd1));
        clear_cnt_s = rtc_load_s | field_wr_s;
        wr_nib_s    = bus.DATA_IN[3:0];

        presc_s = (clear_cnt_s || tick_s) ? {PW{1'b0}} : presc_r + PW'(1);
        if (clear_cnt_s || sec_event_s) begin
            subsec_s = 6'd0;
        end else begin
            subsec_s = tick_s ? subsec_r + 6'd1 : subsec_r;
        end

        cal_s       = cal_r;
        hold_s      = hold_r;
        pending_s   = pending_r;
        sec_pulse_s = 1'b0;
        // The snapshot captures the live value present during the read cycle.
        if (snap_s) begin
            shadow_s = cal_r;
        end else begin
            shadow_s = shadow_r;
        end

        if (rtc_load_s) begin
            cal_s.sec = RTC[6:0];
            cal_s.min = RTC[14:8];
            cal_s.hr  = RTC[21:16];
            cal_s.day = RTC[29:24];
            cal_s.mon = RTC[36:32];
            cal_s.yr  = RTC[47:40];
            cal_s.dow = RTC[50:48];
            pending_s = 1'b0;
        end else if (bus_wr_s) begin
            case (bus.ADDR)
                4'h2: begin cal_s.yr[7:4]  = wr_nib_s;      shadow_s.yr[7:4]  = wr_nib_s;      end
                4'h3: begin cal_s.yr[3:0]  = wr_nib_s;      shadow_s.yr[3:0]  = wr_nib_s;      end
                4'h4: begin cal_s.mon[4]   = wr_nib_s[0];   shadow_s.mon[4]   = wr_nib_s[0];   end
                4'h5: begin cal_s.mon[3:0] = wr_nib_s;      shadow_s.mon[3:0] = wr_nib_s;      end
                4'h6: begin cal_s.dow      = wr_nib_s[2:0]; shadow_s.dow      = wr_nib_s[2:0]; end
                4'h7: begin cal_s.day[5:4] = wr_nib_s[1:0]; shadow_s.day[5:4] = wr_nib_s[1:0]; end
                4'h8: begin cal_s.day[3:0] = wr_nib_s;      shadow_s.day[3:0] = wr_nib_s;      end
                4'h9: begin cal_s.hr[5:4]  = wr_nib_s[1:0]; shadow_s.hr[5:4]  = wr_nib_s[1:0]; end
                4'hA: begin cal_s.hr[3:0]  = wr_nib_s;      shadow_s.hr[3:0]  = wr_nib_s;      end
                4'hB: begin cal_s.min[6:4] = wr_nib_s[2:0]; shadow_s.min[6:4] = wr_nib_s[2:0]; end
                4'hC: begin cal_s.min[3:0] = wr_nib_s;      shadow_s.min[3:0] = wr_nib_s;      end
                4'hD: begin cal_s.sec[6:4] = wr_nib_s[2:0]; shadow_s.sec[6:4] = wr_nib_s[2:0]; end
                4'hE: begin cal_s.sec[3:0] = wr_nib_s;      shadow_s.sec[3:0] = wr_nib_s;      end
                4'hF: hold_s = bus.DATA_IN[7];
                default: hold_s = hold_r;
            endcase
        end else if (sec_event_s || pending_r) begin
            // A pending second and a fresh one landing together still advance only once.
            if (hold_r) begin
                pending_s = 1'b1;
            end else begin
                cal_s       = cal_inc(cal_r);
                sec_pulse_s = 1'b1;
                pending_s   = 1'b0;
            end
        end else begin
            pending_s = pending_r;
        end
    end

    // State registers.
    always_ff @(posedge CLK_14M or posedge RESET) begin
        if (RESET) begin
            cal_r       <= CAL_RESET;
            shadow_r    <= CAL_RESET;
            presc_r     <= {PW{1'b0}};
            subsec_r    <= 6'd0;
            hold_r      <= 1'b0;
            pending_r   <= 1'b0;
            rtc_tog_r   <= 1'b0;
            sec_pulse_r <= 1'b0;
        end else begin
            cal_r       <= cal_s;
            shadow_r    <= shadow_s;
            presc_r     <= presc_s;
            subsec_r    <= subsec_s;
            hold_r      <= hold_s;
            pending_r   <= pending_s;
            rtc_tog_r   <= RTC[64];
            sec_pulse_r <= sec_pulse_s;
        end
    end

    // Register read mux, ASCII digits taken from the shadow copy.
    always_comb begin
        case (bus.ADDR)
            4'h0:    rd_data_s = {4'h3, CENTURY[7:4]};
            4'h1:    rd_data_s = {4'h3, CENTURY[3:0]};
            4'h2:    rd_data_s = {4'h3, shadow_r.yr[7:4]};
            4'h3:    rd_data_s = {4'h3, shadow_r.yr[3:0]};
            4'h4:    rd_data_s = {4'h3, 3'b000, shadow_r.mon[4]};
            4'h5:    rd_data_s = {4'h3, shadow_r.mon[3:0]};
            4'h6:    rd_data_s = {4'h3, 1'b0, shadow_r.dow};
            4'h7:    rd_data_s = {4'h3, 2'b00, shadow_r.day[5:4]};
            4'h8:    rd_data_s = {4'h3, shadow_r.day[3:0]};
            4'h9:    rd_data_s = {4'h3, 2'b00, shadow_r.hr[5:4]};
            4'hA:    rd_data_s = {4'h3, shadow_r.hr[3:0]};
            4'hB:    rd_data_s = {4'h3, 1'b0, shadow_r.min[6:4]};
            4'hC:    rd_data_s = {4'h3, shadow_r.min[3:0]};
            4'hD:    rd_data_s = {4'h3, 1'b0, shadow_r.sec[6:4]};
            4'hE:    rd_data_s = {4'h3, shadow_r.sec[3:0]};
            default: rd_data_s = {hold_r, pending_r, subsec_r};
        endcase
    end

    assign bus.DATA_OUT = rd_data_s;
    assign SEC_PULSE    = sec_pulse_r;

endmodule

// File: tb/tb_rtc_calendar_core.sv
// ---------------------------------------------------------------------------
// tb_rtc_calendar_core
// Directed bench for rtc_calendar_core at CLK_HZ=600, TICK_HZ=60, i.e. ten
// clocks per tick and 600 clocks per second. Inputs change and outputs are
// sampled around the falling edge; the design works on the rising edge.
// ---------------------------------------------------------------------------
module tb_rtc_calendar_core;
    logic        clk = 1'b0;
    logic        rst;
    logic [64:0] rtc;
    logic        sec_pulse;
    int          n_checks = 0;
    int          n_pass = 0;
    int          pulse_cnt = 0;
    int          base;
    logic [7:0]  d;
    logic [7:0]  c_yr, c_mon, c_day, c_dow, c_hr, c_min, c_sec, c_f;

    rtc_calendar_core_if bus ();

    rtc_calendar_core #(.CLK_HZ(600), .TICK_HZ(60), .CENTURY(8'h20)) dut (
        .CLK_14M   (clk),
        .RESET     (rst),
        .bus       (bus),
        .RTC       (rtc),
        .SEC_PULSE (sec_pulse)
    );

    always #50 clk = ~clk;

    // Count cycles in which SEC_PULSE is high.
    always @(negedge clk) begin
        if (sec_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic peek(input logic [3:0] a, output logic [7:0] v);
        bus.ADDR = a; bus.SEL = 1'b0; bus.WE = 1'b0;
        #1 v = bus.DATA_OUT;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] v);
        bus.ADDR = a; bus.SEL = 1'b1; bus.WE = 1'b0;
        #1 v = bus.DATA_OUT;
        @(negedge clk);
        bus.SEL = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] v);
        bus.ADDR = a; bus.DATA_IN = v; bus.SEL = 1'b1; bus.WE = 1'b1;
        @(negedge clk);
        bus.SEL = 1'b0; bus.WE = 1'b0;
    endtask

    // Peek every register without strobing SEL and rebuild BCD fields.
    task automatic peek_cal();
        logic [7:0] t, u;
        peek(4'h2, t); peek(4'h3, u); c_yr  = {t[3:0], u[3:0]};
        peek(4'h4, t); peek(4'h5, u); c_mon = {t[3:0], u[3:0]};
        peek(4'h6, t);                c_dow = {4'h0, t[3:0]};
        peek(4'h7, t); peek(4'h8, u); c_day = {t[3:0], u[3:0]};
        peek(4'h9, t); peek(4'hA, u); c_hr  = {t[3:0], u[3:0]};
        peek(4'hB, t); peek(4'hC, u); c_min = {t[3:0], u[3:0]};
        peek(4'hD, t); peek(4'hE, u); c_sec = {t[3:0], u[3:0]};
        peek(4'hF, c_f);
    endtask

    task automatic snap_cal();
        logic [7:0] v;
        rd(4'h0, v);
        check_val("snap_reg0", v, 8'h32);
        peek_cal();
    endtask

    task automatic check_cal(input string tag, input logic [7:0] yr, mon, day, dow, hr, mi, se);
        check_val({tag, ".yr"}, c_yr, yr);
        check_val({tag, ".mon"}, c_mon, mon);
        check_val({tag, ".day"}, c_day, day);
        check_val({tag, ".dow"}, c_dow, dow);
        check_val({tag, ".hr"}, c_hr, hr);
        check_val({tag, ".min"}, c_min, mi);
        check_val({tag, ".sec"}, c_sec, se);
    endtask

    task automatic set_time(input logic [7:0] hr, mi, se);
        wr(4'h9, {4'h0, hr[7:4]}); wr(4'hA, {4'h0, hr[3:0]});
        wr(4'hB, {4'h0, mi[7:4]}); wr(4'hC, {4'h0, mi[3:0]});
        wr(4'hD, {4'h0, se[7:4]}); wr(4'hE, {4'h0, se[3:0]});
    endtask

    task automatic set_cal(input logic [7:0] yr, mon, day, hr, mi, se);
        wr(4'h2, {4'h0, yr[7:4]});  wr(4'h3, {4'h0, yr[3:0]});
        wr(4'h4, {4'h0, mon[7:4]}); wr(4'h5, {4'h0, mon[3:0]});
        wr(4'h7, {4'h0, day[7:4]}); wr(4'h8, {4'h0, day[3:0]});
        set_time(hr, mi, se);
    endtask

    function automatic logic [64:0] build_rtc(input logic [7:0] yr, mon, day, dow, hr, mi, se,
                                              input logic tog);
        logic [64:0] r;
        r = '0;
        r[6:0] = se[6:0]; r[14:8] = mi[6:0]; r[21:16] = hr[5:0]; r[29:24] = day[5:0];
        r[36:32] = mon[4:0]; r[47:40] = yr; r[50:48] = dow[2:0]; r[64] = tog;
        return r;
    endfunction

    initial begin
        rst = 1'b1; rtc = '0;
        bus.ADDR = 4'h0; bus.SEL = 1'b0; bus.WE = 1'b0; bus.DATA_IN = 8'h00;
        cyc(3);

        // Reset state
        check_val("rst_pulse", sec_pulse, 1'b0);
        peek(4'h0, d); check_val("rst_reg0", d, 8'h32);
        peek(4'h1, d); check_val("rst_reg1", d, 8'h30);
        peek_cal();
        check_cal("rst", 8'h00, 8'h01, 8'h01, 8'h06, 8'h00, 8'h00, 8'h00);
        check_val("rst_regf", c_f, 8'h00);

        // 1: two seconds from reset
        rst = 1'b0;
        base = pulse_cnt;
        cyc(1200);
        #1 check_val("t1_pulses", pulse_cnt - base, 2);
        snap_cal();
        check_cal("t1", 8'h00, 8'h01, 8'h01, 8'h06, 8'h00, 8'h00, 8'h02);
        check_val("t1_regf", c_f, 8'h00);

        // 2: RTC load and full year rollover
        base = pulse_cnt;
        rtc = build_rtc(8'h23, 8'h12, 8'h31, 8'h00, 8'h23, 8'h59, 8'h59, 1'b1);
        cyc(601);
        #1 check_val("t2_pulses", pulse_cnt - base, 1);
        snap_cal();
        check_cal("t2", 8'h24, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);

        // 3: month-length and leap-year boundaries
        set_cal(8'h24, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59); cyc(600); snap_cal();
        check_cal("leap_feb28", 8'h24, 8'h02, 8'h29, 8'h02, 8'h00, 8'h00, 8'h00);
        set_time(8'h23, 8'h59, 8'h59); cyc(600); snap_cal();
        check_cal("leap_feb29", 8'h24, 8'h03, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00);
        set_cal(8'h23, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59); cyc(600); snap_cal();
        check_cal("noleap_feb28", 8'h23, 8'h03, 8'h01, 8'h04, 8'h00, 8'h00, 8'h00);
        set_cal(8'h23, 8'h04, 8'h30, 8'h23, 8'h59, 8'h59); cyc(600); snap_cal();
        check_cal("apr30", 8'h23, 8'h05, 8'h01, 8'h05, 8'h00, 8'h00, 8'h00);
        set_cal(8'h23, 8'h01, 8'h30, 8'h23, 8'h59, 8'h59); cyc(600); snap_cal();
        check_cal("jan30", 8'h23, 8'h01, 8'h31, 8'h06, 8'h00, 8'h00, 8'h00);
        set_cal(8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59); cyc(600); snap_cal();
        check_cal("yr99", 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);

        // 4: shadow stays coherent until the next register-0 read
        base = pulse_cnt;
        cyc(1800);
        #1 check_val("t4_pulses", pulse_cnt - base, 3);
        rd(4'hD, d); check_val("t4_old_sec_tens", d, 8'h30);
        rd(4'hE, d); check_val("t4_old_sec_ones", d, 8'h30);
        snap_cal();
        check_val("t4_new_sec", c_sec, 8'h03);
        check_val("t4_new_min", c_min, 8'h00);

        // 5: hold, pending saturation, release
        wr(4'hF, 8'h80);
        base = pulse_cnt;
        cyc(1800);
        snap_cal();
        check_val("t5_frozen_sec", c_sec, 8'h03);
        check_val("t5_hold_pend", c_f[7:6], 2'b11);
        check_val("t5_no_pulse", pulse_cnt - base, 0);
        wr(4'hF, 8'h00);
        cyc(2);
        #1 check_val("t5_release_pulse", pulse_cnt - base, 1);
        snap_cal();
        check_val("t5_release_sec", c_sec, 8'h04);
        check_val("t5_release_f", c_f[7:6], 2'b00);

        // 6: RTC toggle, bus write and second event in one cycle
        wr(4'hD, 8'h00);
        cyc(599);
        base = pulse_cnt;
        rtc = build_rtc(8'h19, 8'h07, 8'h15, 8'h03, 8'h12, 8'h34, 8'h56, 1'b0);
        wr(4'hE, 8'h05);
        #1 check_val("t6_no_pulse_now", sec_pulse, 1'b0);
        snap_cal();
        check_cal("t6", 8'h19, 8'h07, 8'h15, 8'h03, 8'h12, 8'h34, 8'h56);
        check_val("t6_regf", c_f, 8'h00);
        check_val("t6_no_pulse", pulse_cnt - base, 0);

        // Reset mid-second returns everything at once
        cyc(300);
        #7 rst = 1'b1;
        #1 check_val("rst2_pulse", sec_pulse, 1'b0);
        peek_cal();
        check_cal("rst2", 8'h00, 8'h01, 8'h01, 8'h06, 8'h00, 8'h00, 8'h00);
        check_val("rst2_regf", c_f, 8'h00);
        cyc(2);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
